store_commit_buffer: RTL and testbench
======================================

Name: store_commit_buffer

Overview:
- Sits directly downstream of the ROB commit port.
- Accepts up to `N` stores per cycle from lanes the ROB is committing, holds them in an in-order circular FIFO, and drains them one at a time to the data-memory port with a valid/ack handshake.
- Committed stores are architectural: squash never flushes this buffer.
- Also supplies halt-drain sequencing: on halt, the processor stops only after every committed store has reached memory.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥ N.
- WIDTH, `N, commit lanes per cycle.
- ADDR_W, 32, store address width.
- DATA_W, 32, store data width.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low (buffer resets when 0 at posedge).
- ct_valid  in  WIDTH  lane i carries a committing store; lanes in program order, lane 0 oldest.
- ct_addr  in  WIDTH*ADDR_W  per-lane store address.
- ct_data  in  WIDTH*DATA_W  per-lane store data.
- ct_size  in  WIDTH*2  per-lane size: 0 byte, 1 half, 2 word.
- halt  in  1  ROB committed a halt this cycle.
- almost_full  out  1  (DEPTH - count) < WIDTH; ROB must not commit stores while high.
- mem_req_valid  out  1  head entry presented to memory.
- mem_req_addr  out  ADDR_W  head address.
- mem_req_data  out  DATA_W  head data.
- mem_req_size  out  2  head size.
- mem_req_ack  in  1  memory accepts the head this cycle.
- count  out  $clog2(DEPTH)+1  occupied entries.
- overflow_err  out  1  sticky; a store was dropped for lack of space.
- halt_done  out  1  halt seen and buffer fully drained.

Behaviour:
- Storage: head/tail pointers of $clog2(DEPTH) bits wrapping naturally, plus an explicit count. Full is count==DEPTH and empty is count==0; pointer equality is never used alone.
- Enqueue:
  - Valid lanes are compacted in lane order into tail, tail+1, and so on; invalid lanes leave no hole.
  - Entries are visible at the head the cycle after the write: enqueue-to-mem_req_valid latency is 1 cycle minimum.
- Dequeue:
  - mem_req_valid = (count>0), driven combinationally from the head entry.
  - Head advances at posedge when mem_req_valid && mem_req_ack.
  - While waiting for ack, mem_req_* are held stable.
  - An ack while empty is ignored.
- Simultaneous enqueue and dequeue:
  - count_next = count + accepted - deq.
  - Space for acceptance is computed from the pre-dequeue count; a same-cycle dequeue does not free a slot for that cycle.
- Overflow: lanes beyond available space are dropped youngest-first and overflow_err is set. It clears only on reset.
- State machine `state`:
  - RUN: accept stores.
    - On halt, go to DRAIN; the stores in that same cycle's lanes are still accepted.
    - If the buffer would be empty after this cycle, go directly to DONE.
  - DRAIN: ct_valid is ignored; any asserted lane sets overflow_err. Go to DONE when count_next==0.
  - DONE: halt_done=1; ignore further stores. Leave only via reset.
- Reset values:
  - Outputs: count=0, mem_req_valid=0, mem_req_addr/data/size=0, overflow_err=0, halt_done=0, almost_full=(WIDTH>DEPTH)=0.
  - Internal: head=tail=0, state=RUN.
  - Entry storage contents are don't-care.
- Reset mid-operation: reset wins over enqueue, ack and halt in the same cycle. Pending stores are discarded.

Optional Feature:
- Macro: STORE_FWD_EN.
- When defined, the block adds:
  - Input ld_addr (ADDR_W).
  - Outputs fwd_hit (1) and fwd_data (DATA_W).
- Forwarding is combinational over the valid entries only. It selects the youngest entry whose addr == ld_addr and size==2 (word).
- A partial-size match (size≠2, same word) drives fwd_hit=0 and asserts an extra output fwd_conflict=1. Loads must stall on fwd_conflict.
- Entries enqueuing in the current cycle are not searched.
- When not defined, these ports do not exist and no comparators are built.

Test Plan:
- Reset sequence:
  - Stimulus: hold reset=0 for 2 cycles with ct_valid=all-1.
  - Required: count=0, mem_req_valid=0, overflow_err=0, halt_done=0.
- Compaction, N=2:
  - Stimulus: ct_valid=2'b10, addr 0x100/data 0xAA in lane 1, ack=1.
  - Required: next cycle mem_req_valid=1, addr=0x100, data=0xAA; the following cycle count=0.
- Backpressure:
  - Stimulus: enqueue 3 stores (0x10, 0x14, 0x18); hold ack=0 for 4 cycles, then ack=1.
  - Required: mem_req_addr stays 0x10 throughout the stall, then 0x14 and 0x18 appear on consecutive cycles.
- Full/wrap:
  - Stimulus: DEPTH=8; fill to 7, then ct_valid=2'b11 with ack=0.
  - Required: almost_full=1 at count 7; one store accepted, lane 1 dropped, overflow_err=1, count=8.
  - Then drain 8 and refill 4: pointer wrap gives correct FIFO order.
- Halt drain:
  - Stimulus: 2 stores pending, halt=1 with one new store, ack=1 each cycle.
  - Required: state reaches DRAIN; halt_done=1 exactly after the 3rd ack; stores arriving in DRAIN set overflow_err.
- STORE_FWD_EN:
  - Stimulus: buffer holds word 0x200=0x11, then word 0x200=0x22; ld_addr=0x200.
  - Required: fwd_hit=1, fwd_data=0x22.
  - With a byte store at 0x200 as the youngest entry: fwd_hit=0, fwd_conflict=1.

Source files
------------

// File: rtl/store_commit_buffer.sv
// In-order store commit buffer: multi-lane enqueue from ROB commit, single-entry memory drain.
// Optional STORE_FWD_EN adds combinational store-to-load forwarding over buffered entries.
module store_commit_buffer #(
   parameter int DEPTH  = 8,
   parameter int WIDTH  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [WIDTH-1:0]          ct_valid,
   input  logic [WIDTH*ADDR_W-1:0]   ct_addr,
   input  logic [WIDTH*DATA_W-1:0]   ct_data,
   input  logic [WIDTH*2-1:0]        ct_size,
   input  logic                      halt,
   output logic                      almost_full,
   output logic                      mem_req_valid,
   output logic [ADDR_W-1:0]         mem_req_addr,
   output logic [DATA_W-1:0]         mem_req_data,
   output logic [1:0]                mem_req_size,
   input  logic                      mem_req_ack,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      overflow_err,
   output logic                      halt_done
`ifdef STORE_FWD_EN
   ,
   input  logic [ADDR_W-1:0]         ld_addr,
   output logic                      fwd_hit,
   output logic [DATA_W-1:0]         fwd_data,
   output logic                      fwd_conflict
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

   state_t            state, state_next;
   logic [PW-1:0]     head, tail;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [1:0]        size_q [DEPTH];

   logic [CW-1:0]     space, n_acc, count_next;
   logic [WIDTH-1:0]  wr_en;
   logic [PW-1:0]     wr_idx [WIDTH];
   logic              deq, drop;

   // Space comes from the pre-dequeue count; valid lanes pack densely from tail.
   always_comb begin
      space = CW'(DEPTH) - count;
      n_acc = '0;
      drop  = 1'b0;
      wr_en = '0;
      for (int i = 0; i < WIDTH; i++) begin
         wr_idx[i] = tail + n_acc[PW-1:0];
         if (ct_valid[i]) begin
            if (state == RUN && n_acc < space) begin
               wr_en[i] = 1'b1;
               n_acc    = n_acc + CW'(1);
            end else if (state != DONE) begin
               drop = 1'b1;
            end
         end
      end
      deq        = mem_req_valid && mem_req_ack;
      count_next = count + n_acc - CW'(deq);
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN: begin
            if (halt) state_next = (count_next == '0) ? DONE : DRAIN;
         end
         DRAIN: begin
            if (count_next == '0) state_next = DONE;
         end
         DONE:    state_next = DONE;
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         overflow_err <= 1'b0;
         state        <= RUN;
      end else begin
         if (deq) head <= head + PW'(1);
         tail  <= tail + n_acc[PW-1:0];
         count <= count_next;
         if (drop) overflow_err <= 1'b1;
         state <= state_next;
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < WIDTH; i++) begin
         if (wr_en[i]) begin
            addr_q[wr_idx[i]] <= ct_addr[i*ADDR_W +: ADDR_W];
            data_q[wr_idx[i]] <= ct_data[i*DATA_W +: DATA_W];
            size_q[wr_idx[i]] <= ct_size[i*2 +: 2];
         end
      end
   end

   assign almost_full   = int'(space) < WIDTH;
   assign mem_req_valid = count != '0;
   assign mem_req_addr  = mem_req_valid ? addr_q[head] : '0;
   assign mem_req_data  = mem_req_valid ? data_q[head] : '0;
   assign mem_req_size  = mem_req_valid ? size_q[head] : '0;
   assign halt_done     = state == DONE;

`ifdef STORE_FWD_EN
   logic [PW-1:0] fidx;

   // Walk oldest to youngest so the last same-word match decides.
   always_comb begin
      fwd_hit      = 1'b0;
      fwd_conflict = 1'b0;
      fwd_data     = '0;
      fidx         = head;
      for (int k = 0; k < DEPTH; k++) begin
         fidx = head + PW'(k);
         if (CW'(k) < count &&
             addr_q[fidx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2]) begin
            if (size_q[fidx] == 2'd2 && addr_q[fidx] == ld_addr) begin
               fwd_hit      = 1'b1;
               fwd_conflict = 1'b0;
               fwd_data     = data_q[fidx];
            end else begin
               fwd_hit      = 1'b0;
               fwd_conflict = 1'b1;
               fwd_data     = '0;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Bench for store_commit_buffer: queue-based reference model plus directed literal checks.
// Define STORE_FWD_EN to also exercise forwarding.
module tb_store_commit_buffer;
   localparam int D = 8;
   localparam int W = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  ct_valid = '0;
   logic [63:0] ct_addr = '0;
   logic [63:0] ct_data = '0;
   logic [3:0]  ct_size = '0;
   logic        halt = 1'b0;
   logic        ack = 1'b0;
   logic        almost_full, mem_req_valid, overflow_err, halt_done;
   logic [31:0] mem_req_addr, mem_req_data;
   logic [1:0]  mem_req_size;
   logic [3:0]  count;
`ifdef STORE_FWD_EN
   logic [31:0] ld_addr = '0;
   logic        fwd_hit, fwd_conflict;
   logic [31:0] fwd_data;
`endif

   store_commit_buffer #(.DEPTH(D), .WIDTH(W), .ADDR_W(32), .DATA_W(32)) dut (
      .clock(clock), .reset(reset),
      .ct_valid(ct_valid), .ct_addr(ct_addr), .ct_data(ct_data),
      .ct_size(ct_size), .halt(halt),
      .almost_full(almost_full), .mem_req_valid(mem_req_valid),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
      .mem_req_size(mem_req_size), .mem_req_ack(ack),
      .count(count), .overflow_err(overflow_err), .halt_done(halt_done)
`ifdef STORE_FWD_EN
      , .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .fwd_conflict(fwd_conflict)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [1:0]  s;
   } ent_t;

   ent_t q[$];
   bit   m_ovf = 0;
   int   m_mode = 0;
   bit   chk_en = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic cmp(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO of stores plus run/drain/done mode (0/1/2).
   always @(posedge clock) begin : model
      int pre;
      int acc;
      bit dq;
      if (!reset) begin
         q.delete();
         m_ovf  = 0;
         m_mode = 0;
      end else begin
         pre = q.size();
         dq  = (pre > 0) && ack;
         acc = 0;
         if (dq) void'(q.pop_front());
         for (int i = 0; i < W; i++) begin
            if (ct_valid[i]) begin
               if (m_mode == 0 && acc < D - pre) begin
                  q.push_back(ent_t'{ct_addr[i*32 +: 32], ct_data[i*32 +: 32],
                                     ct_size[i*2 +: 2]});
                  acc++;
               end else if (m_mode != 2) begin
                  m_ovf = 1;
               end
            end
         end
         if (m_mode == 0 && halt) m_mode = (q.size() == 0) ? 2 : 1;
         else if (m_mode == 1 && q.size() == 0) m_mode = 2;
      end
   end

   always @(negedge clock) begin : compare
      int n;
      if (chk_en) begin
         n = q.size();
         cmp("m_count", 64'(count), 64'(n));
         cmp("m_valid", 64'(mem_req_valid), 64'(n > 0));
         cmp("m_addr", 64'(mem_req_addr), n > 0 ? 64'(q[0].a) : 64'd0);
         cmp("m_data", 64'(mem_req_data), n > 0 ? 64'(q[0].d) : 64'd0);
         cmp("m_size", 64'(mem_req_size), n > 0 ? 64'(q[0].s) : 64'd0);
         cmp("m_afull", 64'(almost_full), 64'((D - n) < W));
         cmp("m_ovf", 64'(overflow_err), 64'(m_ovf));
         cmp("m_hdone", 64'(halt_done), 64'(m_mode == 2));
      end
   end

   task automatic cyc(input logic [1:0] v,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input logic [31:0] a1, input logic [31:0] d1,
                      input logic [1:0] s0, input logic [1:0] s1,
                      input logic h, input logic k);
      ct_valid = v;
      ct_addr  = {a1, a0};
      ct_data  = {d1, d0};
      ct_size  = {s1, s0};
      halt     = h;
      ack      = k;
      @(negedge clock);
   endtask

   initial begin
      logic [31:0] exp_a [8];

      // Reset held two cycles with all lanes valid.
      reset = 1'b0;
      cyc(2'b11, 32'h40, 1, 32'h44, 2, 2, 2, 1'b1, 1'b1);
      chk_en = 1;
      cyc(2'b11, 32'h40, 1, 32'h44, 2, 2, 2, 1'b1, 1'b1);
      cmp("rst_count", 64'(count), 0);
      cmp("rst_valid", 64'(mem_req_valid), 0);
      cmp("rst_ovf", 64'(overflow_err), 0);
      cmp("rst_hdone", 64'(halt_done), 0);
      cmp("rst_afull", 64'(almost_full), 0);
      reset = 1'b1;

      // Compaction: only lane 1 valid.
      cyc(2'b10, 32'hDEAD, 32'h55, 32'h100, 32'hAA, 2, 2, 1'b0, 1'b1);
      cmp("cmp_valid", 64'(mem_req_valid), 1);
      cmp("cmp_addr", 64'(mem_req_addr), 64'h100);
      cmp("cmp_data", 64'(mem_req_data), 64'hAA);
      cyc(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      cmp("cmp_count0", 64'(count), 0);

      // Backpressure.
      cyc(2'b11, 32'h10, 1, 32'h14, 2, 2, 2, 1'b0, 1'b0);
      cyc(2'b01, 32'h18, 3, 0, 0, 2, 0, 1'b0, 1'b0);
      cmp("bp_count", 64'(count), 3);
      for (int i = 0; i < 4; i++) begin
         cmp("bp_hold", 64'(mem_req_addr), 64'h10);
         cyc(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      end
      cmp("bp_hold", 64'(mem_req_addr), 64'h10);
      cyc(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      cmp("bp_2nd", 64'(mem_req_addr), 64'h14);
      cyc(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      cmp("bp_3rd", 64'(mem_req_addr), 64'h18);
      cyc(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      cmp("bp_empty", 64'(count), 0);

      // Fill to 7, then overflow one lane.
      cyc(2'b11, 32'h300, 0, 32'h304, 1, 2, 2, 1'b0, 1'b0);
      cyc(2'b11, 32'h308, 2, 32'h30C, 3, 2, 2, 1'b0, 1'b0);
      cyc(2'b11, 32'h310, 4, 32'h314, 5, 2, 2, 1'b0, 1'b0);
      cmp("full_af6", 64'(almost_full), 0);
      cyc(2'b01, 32'h318, 6, 0, 0, 2, 0, 1'b0, 1'b0);
      cmp("full_cnt7", 64'(count), 7);
      cmp("full_af7", 64'(almost_full), 1);
      cyc(2'b11, 32'h400, 32'h77, 32'h404, 32'h88, 2, 2, 1'b0, 1'b0);
      cmp("full_cnt8", 64'(count), 8);
      cmp("full_ovf", 64'(overflow_err), 1);
      exp_a = '{32'h300, 32'h304, 32'h308, 32'h30C,
                32'h310, 32'h314, 32'h318, 32'h400};
      for (int i = 0; i < 8; i++) begin
         cmp("drain_addr", 64'(mem_req_addr), 64'(exp_a[i]));
         cyc(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      end
      cmp("drain_cnt", 64'(count), 0);
      cyc(2'b11, 32'h500, 32'h50, 32'h504, 32'h51, 2, 1, 1'b0, 1'b0);
      cyc(2'b11, 32'h508, 32'h52, 32'h50C, 32'h53, 0, 2, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cmp("wrap_addr", 64'(mem_req_addr), 64'(32'h500 + 4 * i));
         cmp("wrap_data", 64'(mem_req_data), 64'(32'h50 + i));
         cyc(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      end
      cmp("wrap_cnt", 64'(count), 0);
      cmp("wrap_ovf", 64'(overflow_err), 1);

      // Reset wins over enqueue/halt/ack.
      reset = 1'b0;
      cyc(2'b11, 32'h900, 1, 32'h904, 2, 2, 2, 1'b1, 1'b1);
      reset = 1'b1;
      cmp("rst2_cnt", 64'(count), 0);
      cmp("rst2_ovf", 64'(overflow_err), 0);

      // Halt drain.
      cyc(2'b11, 32'h600, 32'h60, 32'h604, 32'h61, 2, 2, 1'b0, 1'b1);
      cmp("halt_pend", 64'(count), 2);
      cyc(2'b01, 32'h608, 32'h62, 0, 0, 2, 0, 1'b1, 1'b1);
      cmp("halt_cnt", 64'(count), 2);
      cmp("halt_nd1", 64'(halt_done), 0);
      cyc(2'b01, 32'h700, 32'h70, 0, 0, 2, 0, 1'b0, 1'b1);
      cmp("halt_cnt1", 64'(count), 1);
      cmp("halt_addr", 64'(mem_req_addr), 64'h608);
      cmp("halt_nd2", 64'(halt_done), 0);
      cmp("halt_ovf", 64'(overflow_err), 1);
      cyc(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      cmp("halt_done", 64'(halt_done), 1);
      cmp("halt_cnt0", 64'(count), 0);
      cyc(2'b11, 32'h800, 1, 32'h804, 2, 2, 2, 1'b0, 1'b0);
      cmp("done_cnt", 64'(count), 0);
      cmp("done_hold", 64'(halt_done), 1);

`ifdef STORE_FWD_EN
      reset = 1'b0;
      cyc(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      reset = 1'b1;
      ld_addr = 32'h200;
      cyc(2'b11, 32'h200, 32'h11, 32'h200, 32'h22, 2, 2, 1'b0, 1'b0);
      #1;
      cmp("fwd_hit", 64'(fwd_hit), 1);
      cmp("fwd_data", 64'(fwd_data), 64'h22);
      cmp("fwd_conf0", 64'(fwd_conflict), 0);
      ld_addr = 32'h204;
      #1;
      cmp("fwd_miss", 64'(fwd_hit), 0);
      cmp("fwd_miss_c", 64'(fwd_conflict), 0);
      ld_addr = 32'h200;
      @(negedge clock);
      cyc(2'b01, 32'h200, 32'h33, 0, 0, 0, 0, 1'b0, 1'b0);
      #1;
      cmp("fwd_part_hit", 64'(fwd_hit), 0);
      cmp("fwd_part_conf", 64'(fwd_conflict), 1);
      @(negedge clock);
`endif

      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
